periph_timer_pwm: RTL and testbench

Parametrised memory-mapped peripheral bank for the RV32I core: N_PWM PWM channels of configurable resolution with glitch-free double-buffered duty updates, free-running microsecond and millisecond timers, and a millisecond compare-match interrupt. It sits beside the 8 kB data memory on the shared read/write address buses. It decodes its own address window and returns a registered 32-bit word plus a hit flag, which the parent memory muxes in before its sub-word extraction.

---
 rtl/periph_pkg.sv | 18 +
 rtl/pwm_channel.sv | 41 ++++
 rtl/periph_timer_pwm.sv | 203 ++++++++++++++++++++
 tb/tb_periph_timer_pwm.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_pkg.sv
// Shared register-map offsets and control bit positions for the timer/PWM peripheral.
// No logic: constants only; no latency or backpressure of its own.
// Used by periph_timer_pwm for its bus decode and read mux.
package periph_pkg;

    // Byte offsets from the window base; decode compares bits [5:2] only.
    localparam logic [5:0] OFF_CTRL   = 6'h00;
    localparam logic [5:0] OFF_STATUS = 6'h04;
    localparam logic [5:0] OFF_MICROS = 6'h08;
    localparam logic [5:0] OFF_MILLIS = 6'h0C;
    localparam logic [5:0] OFF_CMP    = 6'h10;
    localparam logic [5:0] OFF_DUTY0  = 6'h20;

    // CTRL register bit positions.
    localparam int CTRL_PWM_EN = 0;
    localparam int CTRL_IRQ_EN = 1;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty (shadow) plus comparator against the shared counter.
// Latency: out is combinational from registered state; a duty change lands at the next wrap.
// No backpressure: the duty input is sampled unconditionally on wrap or while disabled.
// Ports: clk, rst_n (async active-low); en = global pwm enable; wrap = shared counter at its
//        last value; counter = shared PWM count; duty = bus-visible DUTY register; out = PWM.
module pwm_channel #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                wrap,
    input  logic [PWM_BITS-1:0] counter,
    input  logic [PWM_BITS-1:0] duty,
    output logic                out
);

    logic [PWM_BITS-1:0] shadow_q;
    logic [PWM_BITS-1:0] shadow_d;

    // Shadow only follows DUTY at a period boundary so a mid-period write
    // can never truncate or stretch the pulse currently being generated.
    // While disabled it tracks DUTY so the first enabled period is correct.
    always_comb begin
        shadow_d = shadow_q;
        if (!en || wrap) begin
            shadow_d = duty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign out = en && (counter < shadow_q);

endmodule

// File: rtl/periph_timer_pwm.sv
// Memory-mapped timer/PWM bank: us/ms free-running timers, ms compare IRQ, N_PWM PWM channels.
// Latency: reads registered (1 cycle); writes land on the next edge; PWM duty at next period.
// No backpressure: every bus access completes in one cycle; a miss returns read_hit=0, data 0.
// Ports: clk, rst_n (async active-low); write_mem/funct3/write_address/write_data = store bus
//        (word stores only); read_address -> read_data/read_hit one cycle later;
//        pwm_out = per-channel PWM; irq = compare flag gated by CTRL.irq_en.
module periph_timer_pwm
    import periph_pkg::*;
#(
    parameter int          CLK_HZ    = 12_000_000,
    parameter int          N_PWM     = 4,
    parameter int          PWM_BITS  = 8,
    parameter logic [31:0] BASE_ADDR = 32'hFFFFFFC0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             write_mem,
    input  logic [2:0]       funct3,
    input  logic [31:0]      write_address,
    input  logic [31:0]      write_data,
    input  logic [31:0]      read_address,
    output logic [31:0]      read_data,
    output logic             read_hit,
    output logic [N_PWM-1:0] pwm_out,
    output logic             irq
);

    localparam int            DIV        = CLK_HZ / 1_000_000;
    localparam int            PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [9:0]    SUB_LAST   = 10'd999;

    if (CLK_HZ <= 0 || (CLK_HZ % 1_000_000) != 0) begin : g_bad_clk_hz
        $error("periph_timer_pwm: CLK_HZ must be a nonzero multiple of 1000000");
    end
    if (N_PWM < 1 || N_PWM > 8) begin : g_bad_n_pwm
        $error("periph_timer_pwm: N_PWM must be 1..8");
    end
    if (PWM_BITS < 1 || PWM_BITS > 16) begin : g_bad_pwm_bits
        $error("periph_timer_pwm: PWM_BITS must be 1..16");
    end
    if (BASE_ADDR[5:0] != 6'd0) begin : g_bad_base
        $error("periph_timer_pwm: BASE_ADDR must be 64-byte aligned");
    end

    // ---------------------------------------------------------------- state
    logic [1:0]          ctrl_q,   ctrl_d;
    logic                flag_q,   flag_d;
    logic [31:0]         micros_q, micros_d;
    logic [31:0]         millis_q, millis_d;
    logic [31:0]         cmp_q,    cmp_d;
    logic [PW-1:0]       presc_q,  presc_d;
    logic [9:0]          sub_q,    sub_d;
    logic [PWM_BITS-1:0] cnt_q,    cnt_d;
    logic [PWM_BITS-1:0] duty_q [N_PWM];
    logic [PWM_BITS-1:0] duty_d [N_PWM];
    logic [31:0]         read_data_q, read_data_d;
    logic                read_hit_q,  read_hit_d;

    logic                us_tick;
    logic                ms_tick;
    logic                cmp_match;
    logic                pwm_en;
    logic                pwm_wrap;
    logic                wr_en;
    logic [3:0]          wr_idx;
    logic                rd_in_win;
    logic [3:0]          rd_idx;

    // Byte-lane bits of both addresses carry no information for word registers.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{read_address[1:0], write_address[1:0]};

    // --------------------------------------------------------------- decode
    assign wr_en     = write_mem && (funct3 == 3'b010)
                       && (write_address[31:6] == BASE_ADDR[31:6]);
    assign wr_idx    = write_address[5:2];
    assign rd_in_win = (read_address[31:6] == BASE_ADDR[31:6]);
    assign rd_idx    = read_address[5:2];

    // --------------------------------------------------------------- timers
    always_comb begin
        us_tick  = (presc_q == PRESC_LAST);
        ms_tick  = us_tick && (sub_q == SUB_LAST);
        presc_d  = us_tick ? '0 : presc_q + PW'(1);
        sub_d    = sub_q;
        if (us_tick) begin
            sub_d = ms_tick ? '0 : sub_q + 10'd1;
        end
        micros_d = us_tick ? micros_q + 32'd1 : micros_q;
        millis_d = ms_tick ? millis_q + 32'd1 : millis_q;
        // Compare only on the cycle MILLIS actually moves, so a CMP equal to the
        // current (static) MILLIS never fires.
        cmp_match = ms_tick && (millis_d == cmp_q);
    end

    // -------------------------------------------------------- bus registers
    always_comb begin
        ctrl_d = ctrl_q;
        cmp_d  = cmp_q;
        flag_d = flag_q;
        for (int k = 0; k < N_PWM; k++) begin
            duty_d[k] = duty_q[k];
        end
        if (wr_en) begin
            case (wr_idx)
                OFF_CTRL[5:2]:   ctrl_d = write_data[1:0];
                OFF_STATUS[5:2]: if (write_data[0]) flag_d = 1'b0;
                OFF_CMP[5:2]:    cmp_d = write_data;
                default: ;
            endcase
            for (int k = 0; k < N_PWM; k++) begin
                if (wr_idx == OFF_DUTY0[5:2] + 4'(k)) begin
                    duty_d[k] = write_data[PWM_BITS-1:0];
                end
            end
        end
        // Set after the W1C so a clear racing a match cannot lose the event.
        if (cmp_match) begin
            flag_d = 1'b1;
        end
    end

    // ---------------------------------------------------- shared PWM counter
    assign pwm_en   = ctrl_q[CTRL_PWM_EN];
    assign pwm_wrap = pwm_en && (cnt_q == '1);
    assign cnt_d    = pwm_en ? cnt_q + PWM_BITS'(1) : '0;

    // ------------------------------------------------------------- read mux
    // Built from current _q values, so a same-cycle write is not yet visible.
    always_comb begin
        read_data_d = '0;
        read_hit_d  = rd_in_win;
        if (rd_in_win) begin
            case (rd_idx)
                OFF_CTRL[5:2]:   read_data_d = {30'd0, ctrl_q};
                OFF_STATUS[5:2]: read_data_d = {31'd0, flag_q};
                OFF_MICROS[5:2]: read_data_d = micros_q;
                OFF_MILLIS[5:2]: read_data_d = millis_q;
                OFF_CMP[5:2]:    read_data_d = cmp_q;
                default: ;
            endcase
            for (int k = 0; k < N_PWM; k++) begin
                if (rd_idx == OFF_DUTY0[5:2] + 4'(k)) begin
                    read_data_d = 32'(duty_q[k]);
                end
            end
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q      <= '0;
            flag_q      <= 1'b0;
            micros_q    <= '0;
            millis_q    <= '0;
            cmp_q       <= '0;
            presc_q     <= '0;
            sub_q       <= '0;
            cnt_q       <= '0;
            read_data_q <= '0;
            read_hit_q  <= 1'b0;
            for (int k = 0; k < N_PWM; k++) begin
                duty_q[k] <= '0;
            end
        end else begin
            ctrl_q      <= ctrl_d;
            flag_q      <= flag_d;
            micros_q    <= micros_d;
            millis_q    <= millis_d;
            cmp_q       <= cmp_d;
            presc_q     <= presc_d;
            sub_q       <= sub_d;
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
            read_hit_q  <= read_hit_d;
            for (int k = 0; k < N_PWM; k++) begin
                duty_q[k] <= duty_d[k];
            end
        end
    end

    assign read_data = read_data_q;
    assign read_hit  = read_hit_q;
    assign irq       = flag_q && ctrl_q[CTRL_IRQ_EN];

    // ------------------------------------------------------------- channels
    for (genvar g = 0; g < N_PWM; g++) begin : g_pwm
        pwm_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (pwm_en),
            .wrap    (pwm_wrap),
            .counter (cnt_q),
            .duty    (duty_q[g]),
            .out     (pwm_out[g])
        );
    end

endmodule

// File: tb/tb_periph_timer_pwm.sv
// Directed bench for periph_timer_pwm with an edge-count based reference model.
// Every bus cycle checks read_data/read_hit; every negedge checks pwm_out and irq.
// Hand-computed literal expectations pin the model at the interesting points.
module tb_periph_timer_pwm;

    localparam int          CLK_HZ   = 12_000_000;
    localparam int          N_PWM    = 4;
    localparam int          PWM_BITS = 8;
    localparam logic [31:0] BASE     = 32'hFFFFFFC0;
    localparam longint      DIV      = 12;
    localparam longint      MS       = 12000;
    localparam longint      PER      = 256;
    localparam longint      NEVER    = 64'h7FFF_FFFF_FFFF_FFFF;

    localparam logic [31:0] A_CTRL   = BASE + 32'h00;
    localparam logic [31:0] A_STATUS = BASE + 32'h04;
    localparam logic [31:0] A_MICROS = BASE + 32'h08;
    localparam logic [31:0] A_MILLIS = BASE + 32'h0C;
    localparam logic [31:0] A_CMP    = BASE + 32'h10;
    localparam logic [31:0] A_DUTY0  = BASE + 32'h20;
    localparam logic [31:0] A_DUTY1  = BASE + 32'h24;
    localparam logic [31:0] A_DUTY2  = BASE + 32'h28;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             write_mem = 1'b0;
    logic [2:0]       funct3 = 3'b000;
    logic [31:0]      write_address = 32'd0;
    logic [31:0]      write_data = 32'd0;
    logic [31:0]      read_address = 32'd0;
    logic [31:0]      read_data;
    logic             read_hit;
    logic [N_PWM-1:0] pwm_out;
    logic             irq;

    always #5 clk = ~clk;

    periph_timer_pwm #(
        .CLK_HZ   (CLK_HZ),
        .N_PWM    (N_PWM),
        .PWM_BITS (PWM_BITS),
        .BASE_ADDR(BASE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_mem    (write_mem),
        .funct3       (funct3),
        .write_address(write_address),
        .write_data   (write_data),
        .read_address (read_address),
        .read_data    (read_data),
        .read_hit     (read_hit),
        .pwm_out      (pwm_out),
        .irq          (irq)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Number of clock edges since reset release: the model's time base.
    longint E = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) E <= 0;
        else        E <= E + 1;
    end

    // ------------------------------------------------------------ model
    typedef struct {
        longint e;
        int     ch;
        int     v;
    } dwr_t;

    logic [1:0]  m_ctrl;
    longint      m_en_edge;
    logic [31:0] m_cmp;
    longint      m_match_e;
    longint      m_last_clr;
    dwr_t        dq[$];
    logic        chk_on = 1'b0;

    task automatic model_reset();
        m_ctrl     = 2'b00;
        m_en_edge  = 0;
        m_cmp      = 32'd0;
        m_match_e  = NEVER;
        m_last_clr = -1;
        dq.delete();
    endtask

    // DUTY value held after edge e (latest write landing at or before e).
    function automatic int duty_at(int ch, longint e);
        int v = 0;
        foreach (dq[i]) begin
            if (dq[i].ch == ch && dq[i].e <= e) v = dq[i].v;
        end
        return v;
    endfunction

    // Each period starts PER edges apart from the enable edge and uses the
    // DUTY value present just before it starts.
    function automatic logic exp_pwm(int ch, longint e);
        longint rel;
        longint pstart;
        if (!m_ctrl[0]) return 1'b0;
        rel    = e - m_en_edge;
        pstart = m_en_edge + (rel / PER) * PER;
        return (rel % PER) < longint'(duty_at(ch, pstart - 1));
    endfunction

    // MILLIS first equals CMP at edge CMP*12000; a clear on that same edge loses.
    function automatic logic exp_flag(longint e);
        return (e >= m_match_e) && (m_last_clr <= m_match_e);
    endfunction

    function automatic logic [32:0] exp_read(logic [31:0] a, longint e);
        logic [31:0] d;
        d = 32'd0;
        if ((a & 32'hFFFFFFC0) != BASE) return 33'd0;
        case (a[5:2])
            4'd0:  d = {30'd0, m_ctrl};
            4'd1:  d = {31'd0, exp_flag(e)};
            4'd2:  d = 32'(e / DIV);
            4'd3:  d = 32'(e / MS);
            4'd4:  d = m_cmp;
            4'd8, 4'd9, 4'd10, 4'd11:
                   d = 32'(duty_at(int'(a[5:2]) - 8, e));
            default: d = 32'd0;
        endcase
        return {1'b1, d};
    endfunction

    task automatic apply_write(logic [3:0] idx, logic [31:0] wd);
        case (idx)
            4'd0: begin
                if (wd[0] && !m_ctrl[0]) m_en_edge = E;
                m_ctrl = wd[1:0];
            end
            4'd1: if (wd[0]) m_last_clr = E;
            4'd4: begin
                m_cmp     = wd;
                m_match_e = (wd == 32'd0) ? NEVER : longint'(wd) * MS;
            end
            4'd8, 4'd9, 4'd10, 4'd11:
                dq.push_back('{e: E, ch: int'(idx) - 8, v: int'(wd[7:0])});
            default: ;
        endcase
    endtask

    // ------------------------------------------------------------ checks
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", name, act, exp, E);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on && rst_n) begin
            for (int k = 0; k < N_PWM; k++) begin
                chk($sformatf("pwm_out[%0d]", k), 32'(pwm_out[k]), 32'(exp_pwm(k, E)));
            end
            chk("irq", 32'(irq), 32'(m_ctrl[1] & exp_flag(E)));
        end
    end

    // ------------------------------------------------------------ driver
    // One bus cycle: inputs applied just after an edge, checked just after the next.
    task automatic bus_cycle(logic we, logic [2:0] f3, logic [31:0] wa, logic [31:0] wd,
                             logic [31:0] ra, string tag);
        logic [32:0] exp;
        exp           = exp_read(ra, E);
        write_mem     = we;
        funct3        = f3;
        write_address = wa;
        write_data    = wd;
        read_address  = ra;
        @(posedge clk);
        #1;
        write_mem = 1'b0;
        chk({tag, "_hit"}, 32'(read_hit), 32'(exp[32]));
        chk({tag, "_data"}, read_data, exp[31:0]);
        if (we && f3 == 3'b010 && (wa & 32'hFFFFFFC0) == BASE) apply_write(wa[5:2], wd);
    endtask

    function automatic logic [31:0] idle_ra();
        return E[0] ? A_MILLIS : A_MICROS;
    endfunction

    task automatic idle();
        bus_cycle(1'b0, 3'b000, 32'd0, 32'd0, idle_ra(), "idle");
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d);
        bus_cycle(1'b1, 3'b010, a, d, idle_ra(), "wr");
    endtask

    task automatic rd(logic [31:0] a, string tag);
        bus_cycle(1'b0, 3'b000, 32'd0, 32'd0, a, tag);
    endtask

    task automatic wait_edge(longint target);
        for (int i = 0; i < 40000 && E < target; i++) idle();
        chk("wait_edge", 32'(E), 32'(target));
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        int h0;
        int h1;
        model_reset();
        #23;
        chk("rst_pwm_out", 32'(pwm_out), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_read_hit", 32'(read_hit), 32'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // MICROS steps from 0 to 1 after exactly 12 edges.
        wait_edge(11);
        rd(A_MICROS, "micros_e11");
        chk("lit_micros_e11", read_data, 32'd0);
        rd(A_MICROS, "micros_e12");
        chk("lit_micros_e12", read_data, 32'd1);

        wr(A_CMP, 32'd3);
        wr(A_DUTY0, 32'd64);
        wr(A_DUTY1, 32'd0);
        wr(A_CTRL, 32'd3);

        // Period 0: duty 64 on ch0, duty 0 on ch1.
        h0 = 0; h1 = 0;
        for (int i = 0; i < 256; i++) begin
            h0 += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
            idle();
        end
        chk("lit_duty64_high", 32'(h0), 32'd64);
        chk("lit_duty0_high", 32'(h1), 32'd0);

        // Period 1: DUTY0 -> 192 at phase 100 must not alter this period.
        h0 = 0;
        for (int i = 0; i < 256; i++) begin
            h0 += int'(pwm_out[0]);
            if (i == 100) wr(A_DUTY0, 32'd192);
            else if (i == 101) begin
                rd(A_DUTY0, "duty0_rb");
                chk("lit_duty0_rb", read_data, 32'd192);
            end else idle();
        end
        chk("lit_midperiod_high", 32'(h0), 32'd64);

        // Period 2: new duty in force.
        h0 = 0;
        for (int i = 0; i < 256; i++) begin
            h0 += int'(pwm_out[0]);
            idle();
        end
        chk("lit_duty192_high", 32'(h0), 32'd192);

        // DUTY1 = 255: exactly one low cycle per period from period 4 on.
        wr(A_DUTY1, 32'd255);
        repeat (255) idle();
        h0 = 0; h1 = 0;
        for (int i = 0; i < 256; i++) begin
            h0 += int'(pwm_out[0]);
            h1 += int'(!pwm_out[1]);
            idle();
        end
        chk("lit_duty255_low", 32'(h1), 32'd1);
        chk("lit_duty192_again", 32'(h0), 32'd192);

        // Same-cycle write and read returns the old value.
        bus_cycle(1'b1, 3'b010, A_DUTY2, 32'd5, A_DUTY2, "rw_same");
        chk("lit_rw_same_old", read_data, 32'd0);
        rd(A_DUTY2, "rw_after");
        chk("lit_rw_after_new", read_data, 32'd5);

        // Non-word stores, out-of-window stores and read-only stores are ignored.
        bus_cycle(1'b1, 3'b000, A_CTRL, 32'd0, idle_ra(), "sb_ctrl");
        bus_cycle(1'b1, 3'b001, A_CTRL, 32'd0, idle_ra(), "sh_ctrl");
        bus_cycle(1'b1, 3'b010, 32'h7FFFFFC0, 32'd0, idle_ra(), "oow_wr");
        wr(A_MICROS, 32'd0);
        rd(A_CTRL, "ctrl_rb");
        chk("lit_ctrl_kept", read_data, 32'd3);
        rd(BASE + 32'h14, "unmapped");
        chk("lit_unmapped_hit", 32'(read_hit), 32'd1);
        chk("lit_unmapped_data", read_data, 32'd0);
        rd(32'h0000_0100, "miss");
        chk("lit_miss_hit", 32'(read_hit), 32'd0);
        chk("lit_miss_data", read_data, 32'd0);

        // pwm_en = 0 forces all outputs low; then re-enable.
        wr(A_CTRL, 32'd2);
        repeat (3) idle();
        chk("lit_pwm_disabled", 32'(pwm_out), 32'd0);
        wr(A_CTRL, 32'd3);
        repeat (20) idle();

        // MILLIS steps from 0 to 1 after exactly 12000 edges.
        wait_edge(11999);
        rd(A_MILLIS, "millis_e11999");
        chk("lit_millis_e11999", read_data, 32'd0);
        rd(A_MILLIS, "millis_e12000");
        chk("lit_millis_e12000", read_data, 32'd1);

        // Match at edge 36000 with a W1C landing on the same edge.
        wait_edge(35999);
        chk("lit_irq_before", 32'(irq), 32'd0);
        bus_cycle(1'b1, 3'b010, A_STATUS, 32'd1, A_MILLIS, "match_w1c");
        chk("lit_millis_pre_match", read_data, 32'd2);
        chk("lit_irq_after_match", 32'(irq), 32'd1);
        rd(A_STATUS, "status_set");
        chk("lit_status_set", read_data, 32'd1);
        rd(A_MILLIS, "millis3");
        chk("lit_millis3", read_data, 32'd3);
        repeat (5) idle();
        wr(A_STATUS, 32'd1);
        chk("lit_irq_cleared", 32'(irq), 32'd0);
        rd(A_STATUS, "status_clr");
        chk("lit_status_clr", read_data, 32'd0);

        // Asynchronous reset while pwm_out[0] is high.
        for (int i = 0; i < 300 && pwm_out[0] !== 1'b1; i++) idle();
        chk("lit_pwm0_high_pre_rst", 32'(pwm_out[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("lit_async_pwm_out", 32'(pwm_out), 32'd0);
        chk("lit_async_irq", 32'(irq), 32'd0);
        chk("lit_async_read_data", read_data, 32'd0);
        chk("lit_async_read_hit", 32'(read_hit), 32'd0);
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        repeat (30) idle();
        rd(A_CTRL, "ctrl_post_rst");
        chk("lit_ctrl_post_rst", read_data, 32'd0);
        rd(A_DUTY0, "duty0_post_rst");
        chk("lit_duty0_post_rst", read_data, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
